// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter. Sends one DATA_BITS-wide word per accepted
//            request as a start bit, LSB-first data bits, an optional parity
//            bit and one stop bit. Bit timing comes from an external
//            OVERSAMPLE-times-baud tick (b_tick).
// Options  : define UART_TX_PARITY_EN to compile in the parity bit; the
//            PARITY_ODD parameter then selects odd (1) or even (0) parity.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Counter widths; guarded so degenerate parameter values still elaborate.
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // Frame sequencer states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q,    state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0]  shreg_q,    shreg_d;
  logic                  tx_q,       tx_d;
  logic                  tx_busy_q,  tx_busy_d;
  logic                  tx_done_q,  tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q,   parity_d;
`endif

  // A bit period ends on the last oversample tick of the current bit.
  logic bit_end;
  assign bit_end = b_tick && (tick_cnt_q == TICK_LAST);

  // Next-state, counter, shift-register and registered-output computation.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    // Oversample counter runs only while a frame is in flight; a tick that
    // coincides with acceptance in IDLE is deliberately not counted.
    if (state_q != S_IDLE && b_tick) begin
      if (bit_end) begin
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shreg_d    = tx_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
          // Parity is taken from the captured word, before any shifting.
          parity_d   = (^tx_data) ^ PARITY_ODD;
`endif
          state_d    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    // Outputs are registered from the next state so tx changes exactly at
    // the bit boundary and busy rises the cycle after acceptance.
    tx_busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Single state register for the sequencer and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the dual-watch UART path: serialises one byte per request onto `tx` as 8N1 (optional parity) frames, timed by the shared 16× oversampling baud tick `b_tick`. Sits beside the receiver inside the `uart` wrapper and feeds the serial output pin. In loopback, the receiver's `rx_done`/`rx_data` drive `tx_start`/`tx_data` directly.

## Interface
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `OVERSAMPLE`, 16: `b_tick` pulses per bit period.
- `clk` input 1: system clock (100 MHz in the dual-watch build).
- `rst` input 1: synchronous, active-high reset.
- `b_tick` input 1: one-`clk` pulse at 16× baud from the baud generator.
- `tx_start` input 1: single-cycle transmit request; sampled only when idle.
- `tx_data` input DATA_BITS: byte to send; captured in the cycle `tx_start` is accepted.
- `tx` output 1: serial line, registered, idles high.
- `tx_busy` output 1: high from the cycle after acceptance until the frame completes.
- `tx_done` output 1: one-`clk` pulse marking frame completion.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Counters: `tick_cnt` (log2 OVERSAMPLE bits) and `bit_cnt` (log2 DATA_BITS bits). A state boundary occurs on `b_tick && tick_cnt == OVERSAMPLE-1`. On that boundary `tick_cnt` wraps to 0; otherwise it increments on each `b_tick`.
- IDLE: `tx=1`. When `tx_start=1`, the block latches `tx_data` into the shift register, clears both counters and moves to START. `tx_start` is ignored in every other state; data is not queued.
- START: `tx=0` for one bit period, then DATA.
- DATA: `tx` = shift register LSB. At each bit boundary the register shifts right and `bit_cnt` increments. After bit `DATA_BITS-1`, go to PARITY (macro) or STOP.
- PARITY: `tx` = parity bit for one bit period, then STOP.
- STOP: `tx=1` for one bit period. At the boundary, go to IDLE and pulse `tx_done`.
- `tx_data` changes after acceptance have no effect on the frame in flight.
- `rst`, including mid-frame: next state IDLE, `tx=1`, `tx_busy=0`, `tx_done=0`, counters and shift register cleared. The partial frame is abandoned.

## Timing
- Reset values: `tx=1`, `tx_busy=0`, `tx_done=0`.
- Acceptance in cycle N: `tx` falls and `tx_busy` rises at N+1.
- The start bit ends on the 16th `b_tick` after N+1. Its length therefore varies by less than one `b_tick` period from request phase. Every later bit is exactly 16 `b_tick` periods.
- 8N1 frame = 10 bit periods = 160 `b_tick`s. At 9600 baud with a 100 MHz `clk` (`b_tick` every 651 clk) the bit period is 104160 ns.
- `tx_done` is high for exactly one cycle: the first cycle back in IDLE. `tx_busy` is 0 in that same cycle.
- `tx_start` is accepted in the `tx_done` cycle, giving a back-to-back frame with no extra idle bit.
- `b_tick` high for consecutive cycles counts once per cycle; the block needs no minimum `b_tick` spacing.
- `tx_start` and `b_tick` in the same IDLE cycle: accepted; that tick is not counted.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state compiled in; frame = 11 bit periods.
  - Parity is even: XOR of the latched data bits.
  - Parameter `PARITY_ODD` (default 0) inverts it.
- Undefined: no PARITY state; frame is 8N1, 10 bit periods. `PARITY_ODD` is absent.

## Test plan
- Reset idle: hold `rst` 2 cycles, release, run 1000 cycles with no `tx_start` -> `tx=1`, `tx_busy=0`, `tx_done` never high.
- Single frame: pulse `tx_start` with `tx_data=8'h30`, `b_tick` every 651 clk -> `tx` sequence is 0, then 0,0,0,0,1,1,0,0, then 1; each bit after the start lasts 104160 ns; `tx_done` is a single pulse about 1.0416 ms after the request.
- Busy rejection: pulse `tx_start` with `8'hA5` mid-DATA of an `8'h30` frame -> the `8'h30` frame is unchanged, no second frame follows, and exactly one `tx_done`.
- Back-to-back: drive `tx_start=tx_done` with `tx_data=8'h55` -> the second frame's start bit begins the cycle after the first `tx_done`, with no idle high gap beyond the stop bit.
- Reset mid-frame: assert `rst` during DATA bit 3 -> the next cycle has `tx=1`, `tx_busy=0`; a new `8'h0F` request then transmits correctly.
- Parity (macro defined): send `8'h30` with `PARITY_ODD=0` -> parity bit 0; with `PARITY_ODD=1` -> parity bit 1; frame = 11 bit periods.
